// File: rtl/ctr_obs_queue_cmp_if.sv
// rtl/ctr_obs_queue_cmp_if.sv - observation and result bundle between the two copies and the comparator
interface ctr_obs_queue_cmp_if #(
  parameter int NUM_FIELDS = 14,
  parameter int FIELD_W    = 32,
  parameter int CNT_W      = 16
);
  logic [NUM_FIELDS-1:0]         obs_mask_i;
  logic                          retire_1_i;
  logic [NUM_FIELDS*FIELD_W-1:0] obs_1_i;
  logic                          retire_2_i;
  logic [NUM_FIELDS*FIELD_W-1:0] obs_2_i;
  logic                          final_i;
  logic                          ctr_equiv_o;
  logic [NUM_FIELDS-1:0]         mismatch_field_o;
  logic [CNT_W-1:0]              mismatch_idx_o;
  logic [CNT_W-1:0]              compared_cnt_o;
  logic                          overflow_o;
  logic                          length_mismatch_o;

  modport master (
    output obs_mask_i, retire_1_i, obs_1_i, retire_2_i, obs_2_i, final_i,
    input  ctr_equiv_o, mismatch_field_o, mismatch_idx_o, compared_cnt_o,
           overflow_o, length_mismatch_o
  );

  modport slave (
    input  obs_mask_i, retire_1_i, obs_1_i, retire_2_i, obs_2_i, final_i,
    output ctr_equiv_o, mismatch_field_o, mismatch_idx_o, compared_cnt_o,
           overflow_o, length_mismatch_o
  );
endinterface

// File: rtl/ctr_obs_queue_cmp.sv
// rtl/ctr_obs_queue_cmp.sv - two-FIFO retirement observation comparator with sticky equivalence
module ctr_obs_queue_cmp #(
  parameter int NUM_FIELDS = 14,
  parameter int FIELD_W    = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  ctr_obs_queue_cmp_if.slave     bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int OBS_W = NUM_FIELDS * FIELD_W;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {ST_CHECK, ST_FAIL} state_t;

  state_t                r_state;
  logic [OBS_W-1:0]      r_mem1 [DEPTH];
  logic [OBS_W-1:0]      r_mem2 [DEPTH];
  logic [AW-1:0]         r_rd1, r_wr1, r_rd2, r_wr2;
  logic [AW:0]           r_cnt1, r_cnt2;
  logic                  r_equiv;
  logic [NUM_FIELDS-1:0] r_mfield;
  logic [CNT_W-1:0]      r_midx;
  logic [CNT_W-1:0]      r_ccnt;
  logic                  r_ovf;
  logic                  r_len;

  logic                  w_pop, w_push1, w_push2, w_drop, w_len_mm, w_mismatch;
  logic [AW:0]           w_cnt1_nxt, w_cnt2_nxt;
  logic [OBS_W-1:0]      w_head1, w_head2;
  logic [NUM_FIELDS-1:0] w_diff;

  // A full FIFO still accepts a push when the heads pop on the same edge.
  assign w_pop      = (r_cnt1 != '0) && (r_cnt2 != '0);
  assign w_push1    = bus.retire_1_i && ((r_cnt1 != FULL_CNT) || w_pop);
  assign w_push2    = bus.retire_2_i && ((r_cnt2 != FULL_CNT) || w_pop);
  assign w_drop     = (bus.retire_1_i && !w_push1) || (bus.retire_2_i && !w_push2);
  assign w_cnt1_nxt = r_cnt1 + {{AW{1'b0}}, w_push1} - {{AW{1'b0}}, w_pop};
  assign w_cnt2_nxt = r_cnt2 + {{AW{1'b0}}, w_push2} - {{AW{1'b0}}, w_pop};
  assign w_len_mm   = bus.final_i && (w_cnt1_nxt != w_cnt2_nxt);
  assign w_head1    = r_mem1[r_rd1];
  assign w_head2    = r_mem2[r_rd2];

  always_comb begin
    w_diff = '0;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      w_diff[k] = bus.obs_mask_i[k] &&
                  (w_head1[k*FIELD_W +: FIELD_W] != w_head2[k*FIELD_W +: FIELD_W]);
    end
  end

  assign w_mismatch = w_pop && (w_diff != '0);

  always_ff @(posedge clk_i) begin
    if (w_push1) r_mem1[r_wr1] <= bus.obs_1_i;
    if (w_push2) r_mem2[r_wr2] <= bus.obs_2_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_CHECK;
      r_rd1    <= '0;
      r_wr1    <= '0;
      r_rd2    <= '0;
      r_wr2    <= '0;
      r_cnt1   <= '0;
      r_cnt2   <= '0;
      r_equiv  <= 1'b1;
      r_mfield <= '0;
      r_midx   <= '0;
      r_ccnt   <= '0;
      r_ovf    <= 1'b0;
      r_len    <= 1'b0;
    end else begin
      if (w_push1) r_wr1 <= r_wr1 + 1'b1;
      if (w_push2) r_wr2 <= r_wr2 + 1'b1;
      if (w_pop) begin
        r_rd1 <= r_rd1 + 1'b1;
        r_rd2 <= r_rd2 + 1'b1;
        if (r_ccnt != '1) r_ccnt <= r_ccnt + 1'b1;
      end
      r_cnt1 <= w_cnt1_nxt;
      r_cnt2 <= w_cnt2_nxt;
      if (w_drop)   r_ovf <= 1'b1;
      if (w_len_mm) r_len <= 1'b1;
      case (r_state)
        ST_CHECK: begin
          // A field mismatch on the same edge as an error keeps its diff as the diagnostic.
          if (w_mismatch) begin
            r_state  <= ST_FAIL;
            r_mfield <= w_diff;
            r_midx   <= r_ccnt;
            r_equiv  <= 1'b0;
          end else if (w_drop || w_len_mm) begin
            r_state  <= ST_FAIL;
            r_mfield <= '0;
            r_equiv  <= 1'b0;
          end
        end
        default: r_state <= ST_FAIL;
      endcase
    end
  end

  assign bus.ctr_equiv_o       = r_equiv;
  assign bus.mismatch_field_o  = r_mfield;
  assign bus.mismatch_idx_o    = r_midx;
  assign bus.compared_cnt_o    = r_ccnt;
  assign bus.overflow_o        = r_ovf;
  assign bus.length_mismatch_o = r_len;
endmodule

// File: tb/tb_ctr_obs_queue_cmp.sv
// tb/tb_ctr_obs_queue_cmp.sv - directed and randomized checks of ctr_obs_queue_cmp against a queue model
module tb_ctr_obs_queue_cmp;
  localparam int NF    = 14;
  localparam int FW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int OW    = NF * FW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctr_obs_queue_cmp_if #(.NUM_FIELDS(NF), .FIELD_W(FW), .CNT_W(CW)) bus ();

  ctr_obs_queue_cmp #(.NUM_FIELDS(NF), .FIELD_W(FW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [OW-1:0] q1[$];
  logic [OW-1:0] q2[$];
  int            m_cnt;
  bit            m_fail, m_ovf, m_len;
  logic [NF-1:0] m_mfield;
  int            m_midx;
  logic [OW-1:0] gen [64];
  logic [NF-1:0] all_on;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [NF-1:0] field_diff(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                               input logic [NF-1:0] mask);
    logic [NF-1:0] d;
    d = '0;
    for (int k = 0; k < NF; k++)
      if (mask[k] && a[k*FW +: FW] != b[k*FW +: FW]) d[k] = 1'b1;
    return d;
  endfunction

  task automatic check_all();
    chk("equiv",  {31'd0, bus.ctr_equiv_o}, {31'd0, !m_fail});
    chk("mfield", {18'd0, bus.mismatch_field_o}, {18'd0, m_mfield});
    chk("midx",   {16'd0, bus.mismatch_idx_o}, m_midx);
    chk("ccnt",   {16'd0, bus.compared_cnt_o}, m_cnt);
    chk("ovf",    {31'd0, bus.overflow_o}, {31'd0, m_ovf});
    chk("len",    {31'd0, bus.length_mismatch_o}, {31'd0, m_len});
  endtask

  task automatic step(input bit r1, input logic [OW-1:0] o1, input bit r2, input logic [OW-1:0] o2,
                      input logic [NF-1:0] mask, input bit fin, input bit rs);
    logic [OW-1:0] h1, h2;
    logic [NF-1:0] d;
    bit ev;
    rst = rs;
    bus.retire_1_i = r1;
    bus.obs_1_i    = o1;
    bus.retire_2_i = r2;
    bus.obs_2_i    = o2;
    bus.obs_mask_i = mask;
    bus.final_i    = fin;
    @(posedge clk);
    if (rs) begin
      q1.delete(); q2.delete();
      m_cnt = 0; m_fail = 0; m_ovf = 0; m_len = 0; m_mfield = '0; m_midx = 0;
    end else begin
      if (q1.size() > 0 && q2.size() > 0) begin
        h1 = q1.pop_front();
        h2 = q2.pop_front();
        d = field_diff(h1, h2, mask);
        if (d != '0 && !m_fail) begin
          m_fail = 1; m_mfield = d; m_midx = m_cnt;
        end
        if (m_cnt < 65535) m_cnt++;
      end
      ev = 0;
      if (r1) begin
        if (q1.size() < DEPTH) q1.push_back(o1);
        else begin m_ovf = 1; ev = 1; end
      end
      if (r2) begin
        if (q2.size() < DEPTH) q2.push_back(o2);
        else begin m_ovf = 1; ev = 1; end
      end
      if (fin && q1.size() != q2.size()) begin m_len = 1; ev = 1; end
      if (ev) m_fail = 1;
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, all_on, 0, 0);
  endtask

  task automatic do_reset();
    step(0, '0, 0, '0, all_on, 0, 1);
  endtask

  initial begin
    logic [OW-1:0] o1, o2;
    logic [NF-1:0] mask13;
    all_on = '1;
    mask13 = all_on;
    mask13[13] = 1'b0;
    for (int i = 0; i < 64; i++)
      for (int k = 0; k < NF; k++) gen[i][k*FW +: FW] = $urandom;

    do_reset();
    chk("rst_equiv", {31'd0, bus.ctr_equiv_o}, 32'd1);
    chk("rst_ccnt", {16'd0, bus.compared_cnt_o}, 32'd0);

    // lock-step, identical
    for (int i = 0; i < 8; i++) step(1, gen[i], 1, gen[i], all_on, 0, 0);
    idle(1);
    chk("t1_ccnt", {16'd0, bus.compared_cnt_o}, 32'd8);
    chk("t1_equiv", {31'd0, bus.ctr_equiv_o}, 32'd1);
    chk("t1_mfield", {18'd0, bus.mismatch_field_o}, 32'd0);

    // skewed retirement
    do_reset();
    for (int i = 0; i < 3; i++) step(1, gen[i], 0, '0, all_on, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 1, gen[i], all_on, 0, 0);
    idle(1);
    chk("t2_ccnt", {16'd0, bus.compared_cnt_o}, 32'd3);
    chk("t2_ovf", {31'd0, bus.overflow_o}, 32'd0);
    chk("t2_equiv", {31'd0, bus.ctr_equiv_o}, 32'd1);

    // divergence in field 13, then a later field-0 diff
    do_reset();
    for (int i = 0; i < 5; i++) begin
      o1 = gen[i];
      o1[13*FW +: FW] = 32'h10;
      o2 = o1;
      if (i == 2) o2[13*FW +: FW] = 32'h20;
      if (i == 4) o2[0] = ~o2[0];
      step(1, o1, 1, o2, all_on, 0, 0);
    end
    idle(1);
    chk("t3_equiv", {31'd0, bus.ctr_equiv_o}, 32'd0);
    chk("t3_midx", {16'd0, bus.mismatch_idx_o}, 32'd2);
    chk("t3_mfield", {18'd0, bus.mismatch_field_o}, 32'h2000);
    chk("t3_ccnt", {16'd0, bus.compared_cnt_o}, 32'd5);

    // same field-13 diff masked off
    do_reset();
    o1 = gen[9];
    o1[13*FW +: FW] = 32'h10;
    o2 = o1;
    o2[13*FW +: FW] = 32'h20;
    step(1, o1, 1, o2, mask13, 0, 0);
    step(0, '0, 0, '0, mask13, 0, 0);
    chk("t4_equiv", {31'd0, bus.ctr_equiv_o}, 32'd1);
    chk("t4_ccnt", {16'd0, bus.compared_cnt_o}, 32'd1);

    // overflow on copy 1
    do_reset();
    for (int i = 0; i < 5; i++) step(1, gen[i], 0, '0, all_on, 0, 0);
    chk("t5_ovf", {31'd0, bus.overflow_o}, 32'd1);
    chk("t5_equiv", {31'd0, bus.ctr_equiv_o}, 32'd0);
    step(0, '0, 1, gen[50], all_on, 0, 0);
    idle(1);
    chk("t5_mfield_frozen", {18'd0, bus.mismatch_field_o}, 32'd0);
    chk("t5_ccnt", {16'd0, bus.compared_cnt_o}, 32'd1);

    // final with unequal counts, then reset
    do_reset();
    step(1, gen[0], 1, gen[0], all_on, 0, 0);
    step(1, gen[1], 0, '0, all_on, 0, 0);
    step(0, '0, 0, '0, all_on, 1, 0);
    chk("t6_len", {31'd0, bus.length_mismatch_o}, 32'd1);
    chk("t6_equiv", {31'd0, bus.ctr_equiv_o}, 32'd0);
    do_reset();
    chk("t6_rst_len", {31'd0, bus.length_mismatch_o}, 32'd0);
    chk("t6_rst_equiv", {31'd0, bus.ctr_equiv_o}, 32'd1);
    chk("t6_rst_ccnt", {16'd0, bus.compared_cnt_o}, 32'd0);

    // randomized segments
    for (int seg = 0; seg < 4; seg++) begin
      int i1, i2;
      logic [NF-1:0] mask;
      bit r1, r2, fin;
      do_reset();
      i1 = 0; i2 = 0;
      mask = (seg == 2) ? NF'($urandom) : all_on;
      for (int c = 0; c < 250; c++) begin
        r1 = ($urandom_range(0, 99) < 50);
        r2 = (seg == 0) ? r1 : ($urandom_range(0, 99) < 50);
        o1 = gen[i1 % 64];
        o2 = gen[i2 % 64];
        if ($urandom_range(0, 59) == 0) o2[$urandom_range(0, OW-1)] ^= 1'b1;
        fin = ($urandom_range(0, 79) == 0);
        step(r1, o1, r2, o2, mask, fin, 0);
        if (r1) i1++;
        if (r2) i2++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
